// File: rtl/fifo_unpack.sv
// fifo_unpack: pops wide words from a first-word-fall-through FIFO read port
// and replays each one as P_RATIO narrow beats on a registered valid/ready
// stream, least-significant slice first, with no bubbles between words.
// P_RATIO must be >= 1 and divide P_DATA_WIDTH exactly.
module fifo_unpack #(
   parameter int P_DATA_WIDTH = 32,
   parameter int P_RATIO      = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   output logic                              fifo_read,
   input  logic [P_DATA_WIDTH-1:0]           fifo_data,
   input  logic                              fifo_empty,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [P_DATA_WIDTH/P_RATIO-1:0]   out_data,
   output logic                              out_last
);

   localparam int W     = P_DATA_WIDTH / P_RATIO;
   localparam int IDX_W = (P_RATIO > 1) ? $clog2(P_RATIO) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_RATIO - 1);

   logic [P_DATA_WIDTH-1:0] word_q, word_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    vld_q, vld_d;
   logic                    accept;
   logic                    at_end;
   logic                    pop;

   assign accept = vld_q & out_ready;
   assign at_end = (idx_q == LAST_IDX);

   // Refill when the beat register is empty or its final beat leaves this
   // cycle, so the next word's beat 0 follows the last beat without a gap.
   assign pop       = !rst & !fifo_empty & (!vld_q | (accept & at_end));
   assign fifo_read = pop;

   assign out_valid = vld_q;
   assign out_last  = vld_q & at_end;

   // Next-state: a pop overrides beat advance; otherwise step or retire the word.
   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      vld_d  = vld_q;
      if (pop) begin
         word_d = fifo_data;
         idx_d  = '0;
         vld_d  = 1'b1;
      end else if (accept && !at_end) begin
         idx_d = idx_q + IDX_W'(1);
      end else if (accept) begin
         vld_d = 1'b0;
         idx_d = '0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         idx_q  <= '0;
         vld_q  <= 1'b0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
         vld_q  <= vld_d;
      end
   end

   // Beat select from the held word only, keeping fifo_data off the output path.
   always_comb begin
      out_data = '0;
      for (int unsigned i = 0; i < P_RATIO; i++) begin
         if (idx_q == IDX_W'(i)) begin
            out_data = word_q[i*W +: W];
         end
      end
   end

endmodule

// File: tb/tb_fifo_unpack.sv
// Bench for fifo_unpack: default build (32/4) with a table of words and a
// beat scoreboard, plus a P_RATIO=1 build exercised by a short sequence.
module tb_fifo_unpack;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Default build
   logic        fifo_read, fifo_empty, out_valid, out_ready, out_last;
   logic [31:0] fifo_data;
   logic [7:0]  out_data;

   // P_RATIO=1 build
   logic        fifo_read1, fifo_empty1, out_valid1, out_ready1, out_last1;
   logic [31:0] fifo_data1, out_data1;

   fifo_unpack #(.P_DATA_WIDTH(32), .P_RATIO(4)) u_dut (
      .clk(clk), .rst(rst),
      .fifo_read(fifo_read), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last));

   fifo_unpack #(.P_DATA_WIDTH(32), .P_RATIO(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .fifo_read(fifo_read1), .fifo_data(fifo_data1), .fifo_empty(fifo_empty1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_data(out_data1), .out_last(out_last1));

   // FWFT FIFO models
   logic [31:0] mem  [0:255];
   logic [31:0] mem1 [0:7];
   int unsigned wr_ptr = 0, rd_ptr = 0, pops = 0;
   int unsigned wr1 = 0, rd1 = 0;

   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_data   = mem[rd_ptr[7:0]];
   assign fifo_empty1 = (wr1 == rd1);
   assign fifo_data1  = mem1[rd1[2:0]];

   always @(posedge clk) begin
      if (fifo_read) begin
         rd_ptr <= rd_ptr + 1;
         pops   <= pops + 1;
      end
      if (fifo_read1) rd1 <= rd1 + 1;
   end

   typedef struct {
      logic [7:0] d;
      logic       l;
   } beat_t;

   typedef struct {
      logic [31:0]     word;
      logic [3:0][7:0] beats;     // expected beats, [0] emitted first
      bit              drain;     // wait for all queued beats and go idle
      logic [7:0]      stall_val; // beat to hold out_ready low on
      int              stall_cyc;
   } vec_t;

   beat_t      exp_q[$];
   int         errors = 0, checks = 0;
   bit         rnd_mode = 0;
   logic [7:0] stall_val = 8'h00;
   int         stall_left = 0, stall_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [31:0] w, input logic [3:0][7:0] b);
      #2;
      mem[wr_ptr[7:0]] = w;
      wr_ptr = wr_ptr + 1;
      for (int j = 0; j < 4; j++) exp_q.push_back('{d: b[j], l: (j == 3)});
   endtask

   task automatic drain(input int bound, output int gaps);
      bit seen;
      int n;
      seen = 0;
      gaps = 0;
      n    = 0;
      while (exp_q.size() > 0 && n < bound) begin
         @(negedge clk);
         n++;
         if (out_valid) seen = 1;
         else if (seen && exp_q.size() > 0) gaps++;
      end
      if (exp_q.size() > 0) begin
         chk("drain_timeout", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   vec_t vt[6];
   int   gaps, pre_pops, grp_words, wait_n;
   logic [31:0] rw;

   initial begin
      vt[0] = '{32'hDDCCBBAA, {8'hDD, 8'hCC, 8'hBB, 8'hAA}, 1'b1, 8'h00, 0};
      vt[1] = '{32'h03020100, {8'h03, 8'h02, 8'h01, 8'h00}, 1'b0, 8'h00, 0};
      vt[2] = '{32'h07060504, {8'h07, 8'h06, 8'h05, 8'h04}, 1'b0, 8'h00, 0};
      vt[3] = '{32'h0B0A0908, {8'h0B, 8'h0A, 8'h09, 8'h08}, 1'b1, 8'h00, 0};
      vt[4] = '{32'h44332211, {8'h44, 8'h33, 8'h22, 8'h11}, 1'b0, 8'h22, 5};
      vt[5] = '{32'h88776655, {8'h88, 8'h77, 8'h66, 8'h55}, 1'b1, 8'h00, 0};

      rst        = 1'b1;
      out_ready  = 1'b0;
      out_ready1 = 1'b1;

      fork
         // Monitor: scoreboard plus stream-protocol properties, sampled at negedge
         begin : monitor
            logic       pv, pacc, prst, pl, acc;
            logic [7:0] pd;
            beat_t      e;
            pv = 0; pacc = 0; prst = 1; pl = 0; pd = '0;
            forever begin
               @(negedge clk);
               acc = out_valid && out_ready && !rst;
               if (fifo_read) chk("pop_not_empty", {31'd0, fifo_empty}, 32'd0);
               if (rst) chk("pop_in_reset", {31'd0, fifo_read}, 32'd0);
               if (out_valid && !out_ready) chk("bp_no_pop", {31'd0, fifo_read}, 32'd0);
               if (fifo_read && out_valid)
                  chk("pop_on_last_accept", {31'd0, acc && out_last}, 32'd1);
               if (acc) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_beat", {24'd0, out_data}, 32'hFFFFFFFF);
                  end else begin
                     e = exp_q.pop_front();
                     chk("beat_data", {24'd0, out_data}, {24'd0, e.d});
                     chk("beat_last", {31'd0, out_last}, {31'd0, e.l});
                  end
               end
               if (pv && !pacc && !prst) begin
                  chk("valid_held", {31'd0, out_valid}, 32'd1);
                  chk("bp_data_hold", {24'd0, out_data}, {24'd0, pd});
                  chk("bp_last_hold", {31'd0, out_last}, {31'd0, pl});
               end
               pv = out_valid; pacc = acc; prst = rst; pd = out_data; pl = out_last;
            end
         end
         // Ready driver: random, scripted stall, or always ready
         begin : driver
            forever begin
               @(posedge clk);
               #1;
               if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
               else if (stall_left > 0 && out_valid && out_data == stall_val) begin
                  out_ready = 1'b0;
                  stall_left--;
                  stall_seen++;
               end else out_ready = 1'b1;
            end
         end
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_last", {31'd0, out_last}, 32'd0);
      chk("rst_data", {24'd0, out_data}, 32'd0);
      chk("rst_read", {31'd0, fifo_read}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);

      // Table-driven words
      pre_pops  = int'(pops);
      grp_words = 0;
      for (int i = 0; i < 6; i++) begin
         if (vt[i].stall_cyc > 0) begin
            stall_val  = vt[i].stall_val;
            stall_left = vt[i].stall_cyc;
            stall_seen = 0;
         end
         push_word(vt[i].word, vt[i].beats);
         grp_words++;
         if (vt[i].drain) begin
            drain(400, gaps);
            chk("no_gaps", 32'(gaps), 32'd0);
            @(negedge clk);
            chk("idle_after", {31'd0, out_valid}, 32'd0);
            chk("pop_count", 32'(int'(pops) - pre_pops), 32'(grp_words));
            pre_pops  = int'(pops);
            grp_words = 0;
         end
      end
      chk("stall_cycles", 32'(stall_seen), 32'd5);

      // Reset mid-word: current word discarded, FIFO head popped afterwards
      push_word(32'h44332211, {8'h44, 8'h33, 8'h22, 8'h11});
      push_word(32'h88776655, {8'h88, 8'h77, 8'h66, 8'h55});
      wait_n = 0;
      do begin
         @(negedge clk);
         wait_n++;
      end while (!(out_valid && out_ready && out_data == 8'h11) && wait_n < 50);
      chk("rst_wait_11", {24'd0, out_data}, 32'h11);
      @(posedge clk); #1 rst = 1'b1;
      while (exp_q.size() > 0 && !exp_q[0].l) void'(exp_q.pop_front());
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      @(negedge clk);
      chk("midrst_no_pop", {31'd0, fifo_read}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_data", {24'd0, out_data}, 32'd0);
      chk("midrst_repop", {31'd0, fifo_read}, 32'd1);
      @(negedge clk);
      chk("midrst_head_valid", {31'd0, out_valid}, 32'd1);
      chk("midrst_head_data", {24'd0, out_data}, 32'h55);
      drain(100, gaps);

      // Random ready and random FIFO fill
      rnd_mode = 1;
      for (int k = 0; k < 24; k++) begin
         rw = $urandom;
         push_word(rw, {rw[31:24], rw[23:16], rw[15:8], rw[7:0]});
         repeat ($urandom_range(0, 8)) @(negedge clk);
      end
      drain(3000, gaps);
      rnd_mode = 0;
      repeat (3) @(negedge clk);
      chk("rand_idle", {31'd0, out_valid}, 32'd0);

      // P_RATIO=1 build: registered pass stage
      @(negedge clk);
      #2;
      mem1[0] = 32'h1; mem1[1] = 32'h2; wr1 = 2;
      #1;
      chk("r1_first_pop", {31'd0, fifo_read1}, 32'd1);
      chk("r1_idle_valid", {31'd0, out_valid1}, 32'd0);
      @(negedge clk);
      chk("r1_v0", {31'd0, out_valid1}, 32'd1);
      chk("r1_d0", out_data1, 32'h1);
      chk("r1_l0", {31'd0, out_last1}, 32'd1);
      chk("r1_pop_on_accept", {31'd0, fifo_read1}, 32'd1);
      @(negedge clk);
      chk("r1_v1", {31'd0, out_valid1}, 32'd1);
      chk("r1_d1", out_data1, 32'h2);
      chk("r1_l1", {31'd0, out_last1}, 32'd1);
      chk("r1_no_pop_empty", {31'd0, fifo_read1}, 32'd0);
      @(negedge clk);
      chk("r1_idle", {31'd0, out_valid1}, 32'd0);
      chk("r1_idle_last", {31'd0, out_last1}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time limit
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
